// File: rtl/antic_pkg.sv
// Shared constants and helpers for the ANTIC DMA slot scheduler.
// Covers slot cycle numbers, playfield windows, grant bit indices and DMACTL fields.
package antic_pkg;

  localparam int unsigned H_W   = 7;
  localparam int unsigned V_W   = 9;
  localparam int unsigned GNT_W = 6;

  // Fixed DMA slot positions within a scanline
  localparam int unsigned MIS_CYC   = 0;
  localparam int unsigned DL_CYC    = 1;
  localparam int unsigned PL_FIRST  = 2;
  localparam int unsigned PL_LAST   = 5;
  localparam int unsigned LMS_FIRST = 6;
  localparam int unsigned LMS_LAST  = 7;
  localparam int unsigned VBI_CYC   = 7;
  localparam int unsigned REF_FIRST = 25;
  localparam int unsigned REF_STEP  = 4;
  localparam int unsigned REF_COUNT = 9;
  localparam int unsigned REF_LAST  = REF_FIRST + REF_STEP * (REF_COUNT - 1);

  // Playfield fetch windows per width code
  localparam int unsigned PF_NARROW_LO = 28;
  localparam int unsigned PF_NARROW_HI = 91;
  localparam int unsigned PF_NORMAL_LO = 20;
  localparam int unsigned PF_NORMAL_HI = 99;
  localparam int unsigned PF_WIDE_LO   = 16;
  localparam int unsigned PF_WIDE_HI   = 103;

  // Grant vector bit positions: {ref, pf, lms, pl, dl, mis}
  localparam int unsigned GNT_MIS = 0;
  localparam int unsigned GNT_DL  = 1;
  localparam int unsigned GNT_PL  = 2;
  localparam int unsigned GNT_LMS = 3;
  localparam int unsigned GNT_PF  = 4;
  localparam int unsigned GNT_REF = 5;

  // DMACTL field positions
  localparam int unsigned DMA_PFW_LSB = 0;
  localparam int unsigned DMA_PFW_MSB = 1;
  localparam int unsigned DMA_MIS     = 2;
  localparam int unsigned DMA_PL      = 3;
  localparam int unsigned DMA_DL      = 5;

  typedef enum logic [1:0] {
    PFW_OFF    = 2'b00,
    PFW_NARROW = 2'b01,
    PFW_NORMAL = 2'b10,
    PFW_WIDE   = 2'b11
  } pf_width_e;

  typedef enum logic [1:0] {
    PFR_8 = 2'b00,
    PFR_4 = 2'b01,
    PFR_2 = 2'b10,
    PFR_1 = 2'b11
  } pf_rate_e;

  typedef struct packed {
    logic           en;
    logic [H_W-1:0] lo;
    logic [H_W-1:0] hi;
  } pf_window_t;

  function automatic pf_window_t pf_window(input pf_width_e width);
    pf_window_t w;
    w = '0;
    case (width)
      PFW_NARROW: begin w.en = 1'b1; w.lo = H_W'(PF_NARROW_LO); w.hi = H_W'(PF_NARROW_HI); end
      PFW_NORMAL: begin w.en = 1'b1; w.lo = H_W'(PF_NORMAL_LO); w.hi = H_W'(PF_NORMAL_HI); end
      PFW_WIDE:   begin w.en = 1'b1; w.lo = H_W'(PF_WIDE_LO);   w.hi = H_W'(PF_WIDE_HI);   end
      default:    w = '0;
    endcase
    return w;
  endfunction

  // Low offset bits that must be zero for a fetch at the given interval
  function automatic logic [H_W-1:0] pf_mask(input pf_rate_e rate);
    logic [H_W-1:0] m;
    case (rate)
      PFR_8:   m = H_W'(7);
      PFR_4:   m = H_W'(3);
      PFR_2:   m = H_W'(1);
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/antic_beam_counter.sv
// Horizontal cycle / vertical line counters and the frame timing strobes derived from them.
module antic_beam_counter
  import antic_pkg::*;
#(
  parameter int unsigned H_CYCLES  = 114,
  parameter int unsigned V_LINES   = 262,
  parameter int unsigned ACT_FIRST = 8,
  parameter int unsigned ACT_LAST  = 247
) (
  input  logic           phi2,
  input  logic           rst_L,
  output logic [H_W-1:0] hcount,
  output logic [7:0]     vcount,
  output logic           line_end,
  output logic           line_start,
  output logic           vblank,
  output logic           vbi_start
);

  logic [V_W-1:0] vline;

  always_ff @(posedge phi2 or negedge rst_L) begin
    if (!rst_L) begin
      hcount <= '0;
      vline  <= '0;
    end else if (line_end) begin
      hcount <= '0;
      vline  <= (vline == V_W'(V_LINES - 1)) ? '0 : vline + V_W'(1);
    end else begin
      hcount <= hcount + H_W'(1);
    end
  end

  assign line_end   = (hcount == H_W'(H_CYCLES - 1));
  assign line_start = (hcount == '0);
  assign vblank     = (vline < V_W'(ACT_FIRST)) || (vline > V_W'(ACT_LAST));
  assign vbi_start  = (vline == V_W'(ACT_LAST + 1)) && (hcount == H_W'(VBI_CYC));
  assign vcount     = vline[V_W-1:1];

endmodule

// File: rtl/antic_dma_scheduler.sv
// ANTIC per-cycle DMA slot arbiter: fixed-priority grant decode, refresh deferral and WSYNC stall.
module antic_dma_scheduler
  import antic_pkg::*;
#(
  parameter int unsigned H_CYCLES  = 114,
  parameter int unsigned V_LINES   = 262,
  parameter int unsigned ACT_FIRST = 8,
  parameter int unsigned ACT_LAST  = 247,
  parameter int unsigned WSYNC_REL = 105
) (
  input  logic             phi2,
  input  logic             rst_L,
  input  logic [7:0]       DMACTL,
  input  logic             dl_req,
  input  logic             lms_req,
  input  logic             pf_req,
  input  logic [1:0]       pf_rate,
  input  logic             wsync_wr,
  output logic [GNT_W-1:0] gnt,
  output logic             halt_L,
  output logic             REF_L,
  output logic             RDY_L,
  output logic [H_W-1:0]   hcount,
  output logic [7:0]       VCOUNT,
  output logic             vblank,
  output logic             line_start,
  output logic             vbi_start
);

  logic             line_end;
  logic             ref_pend;
  logic             ref_pend_next;
  logic             wsync_stall;
  logic             wsync_stall_next;
  logic [GNT_W-1:0] gnt_dec;

  pf_window_t       win;
  logic [H_W-1:0]   pf_off;
  logic             mis_ok;
  logic             dl_ok;
  logic             pl_ok;
  logic             lms_ok;
  logic             pf_ok;
  logic             ref_slot;
  logic             dma_busy;
  logic             ref_take;

  antic_beam_counter #(
    .H_CYCLES  (H_CYCLES),
    .V_LINES   (V_LINES),
    .ACT_FIRST (ACT_FIRST),
    .ACT_LAST  (ACT_LAST)
  ) u_beam (
    .phi2       (phi2),
    .rst_L      (rst_L),
    .hcount     (hcount),
    .vcount     (VCOUNT),
    .line_end   (line_end),
    .line_start (line_start),
    .vblank     (vblank),
    .vbi_start  (vbi_start)
  );

  // Zero-latency slot decode; earlier terms in the if-chain win
  always_comb begin
    win      = pf_window(pf_width_e'(DMACTL[DMA_PFW_MSB:DMA_PFW_LSB]));
    pf_off   = hcount - win.lo;
    mis_ok   = !vblank && DMACTL[DMA_MIS] && (hcount == H_W'(MIS_CYC));
    dl_ok    = !vblank && DMACTL[DMA_DL] && dl_req && (hcount == H_W'(DL_CYC));
    pl_ok    = !vblank && DMACTL[DMA_PL]
               && (hcount >= H_W'(PL_FIRST)) && (hcount <= H_W'(PL_LAST));
    lms_ok   = !vblank && DMACTL[DMA_DL] && lms_req
               && (hcount >= H_W'(LMS_FIRST)) && (hcount <= H_W'(LMS_LAST));
    pf_ok    = !vblank && pf_req && win.en
               && (hcount >= win.lo) && (hcount <= win.hi)
               && ((pf_off & pf_mask(pf_rate_e'(pf_rate))) == '0);
    ref_slot = (hcount >= H_W'(REF_FIRST)) && (hcount <= H_W'(REF_LAST))
               && (((hcount - H_W'(REF_FIRST)) % H_W'(REF_STEP)) == '0);
    dma_busy = mis_ok || dl_ok || pl_ok || lms_ok || pf_ok;
    // A deferred refresh rides on the first otherwise idle cycle
    ref_take = !dma_busy && (ref_slot || ref_pend);

    gnt_dec = '0;
    if (mis_ok)        gnt_dec[GNT_MIS] = 1'b1;
    else if (dl_ok)    gnt_dec[GNT_DL]  = 1'b1;
    else if (pl_ok)    gnt_dec[GNT_PL]  = 1'b1;
    else if (lms_ok)   gnt_dec[GNT_LMS] = 1'b1;
    else if (pf_ok)    gnt_dec[GNT_PF]  = 1'b1;
    else if (ref_take) gnt_dec[GNT_REF] = 1'b1;
  end

  // Refresh deferral and WSYNC stall next-state
  always_comb begin
    ref_pend_next    = ref_pend;
    wsync_stall_next = wsync_stall;

    if (line_end)                  ref_pend_next = 1'b0;
    else if (ref_slot && dma_busy) ref_pend_next = 1'b1;
    else if (ref_take)             ref_pend_next = 1'b0;

    if (wsync_stall) wsync_stall_next = (hcount != H_W'(WSYNC_REL - 1));
    else             wsync_stall_next = wsync_wr;
  end

  always_ff @(posedge phi2 or negedge rst_L) begin
    if (!rst_L) begin
      ref_pend    <= 1'b0;
      wsync_stall <= 1'b0;
    end else begin
      ref_pend    <= ref_pend_next;
      wsync_stall <= wsync_stall_next;
    end
  end

  assign gnt    = rst_L ? gnt_dec : '0;
  assign halt_L = ~|gnt;
  assign REF_L  = ~gnt[GNT_REF];
  assign RDY_L  = ~wsync_stall;

endmodule

// File: doc/antic_dma_scheduler.md
Name: antic_dma_scheduler

Overview:
- Per-machine-cycle DMA slot scheduler for ANTIC. It owns the horizontal cycle counter (114 cycles per scanline) and the vertical line counter (262 lines per frame).
- Each cycle it grants the shared system address/data bus to exactly one requester: missile, display list, player, LMS, playfield or refresh. Otherwise the CPU keeps the bus.
- Drives halt_L, RDY_L (WSYNC), REF_L, VCOUNT and frame timing strobes. The display-list FSM and address-bus register are sequenced from its grants.

Parameters:
- H_CYCLES, 114, machine cycles per scanline (hcount wraps at H_CYCLES-1)
- V_LINES, 262, scanlines per frame (vline wraps at V_LINES-1)
- ACT_FIRST, 8, first active (non-vblank) line
- ACT_LAST, 247, last active line
- WSYNC_REL, 105, hcount at which RDY_L releases

Ports:
- phi2  in  1  machine-cycle clock, rising-edge
- rst_L  in  1  asynchronous active-low reset
- DMACTL  in  8  [1:0] playfield width (00 off, 01 narrow, 10 normal, 11 wide); [2] missile DMA; [3] player DMA; [5] display-list DMA
- dl_req  in  1  display-list FSM wants an instruction byte this line
- lms_req  in  1  current instruction needs a 2-byte LMS operand
- pf_req  in  1  current line is a playfield-fetch line
- pf_rate  in  2  fetch interval in the window: 00 every 8, 01 every 4, 10 every 2, 11 every cycle
- wsync_wr  in  1  one-cycle strobe, CPU wrote WSYNC
- gnt  out  6  one-hot {ref, pf, lms, pl, dl, mis}; 0 = CPU owns the bus
- halt_L  out  1  low while any gnt bit is set
- REF_L  out  1  low while gnt[ref] is set
- RDY_L  out  1  low during a WSYNC stall
- hcount  out  7  current cycle in the line
- VCOUNT  out  8  vline[8:1]
- vblank  out  1  high when vline < ACT_FIRST or vline > ACT_LAST
- line_start  out  1  high when hcount==0
- vbi_start  out  1  high for one cycle at vline==ACT_LAST+1, hcount==7

Behaviour:
- Reset (async, rst_L=0): hcount=0, vline=0, ref_pend=0, wsync_stall=0. gnt forced to 0; halt_L=1, REF_L=1, RDY_L=1; vbi_start=0.
- Counters advance on each phi2 rising edge. When hcount==H_CYCLES-1, hcount goes to 0 and vline increments; vline wraps to 0 after V_LINES-1.
- gnt is decoded combinationally from registered hcount, vline, DMACTL and requests, so it applies to the current cycle with zero latency. The highest-priority eligible slot wins.
- Slot rules, checked in priority order:
  - mis: hcount==0, DMACTL[2], !vblank.
  - dl: hcount==1, DMACTL[5], dl_req, !vblank.
  - pl: hcount in 2..5, DMACTL[3], !vblank.
  - lms: hcount in 6..7, DMACTL[5], lms_req, !vblank.
  - pf: hcount in the window, pf_req, !vblank, DMACTL[1:0]!=0, and (hcount-start) mod interval==0.
    - Windows: narrow 28..91, normal 20..99, wide 16..103.
    - pf_rate 11 fetches every cycle of the window.
  - ref: refresh slots at hcount 25,29,...,57 (9 slots, step 4), on all lines including vblank.
    - Slot not blocked: grant ref in that cycle.
    - Slot blocked by pf: set ref_pend. Take the pending refresh at the first later cycle with no other grant, then clear ref_pend.
    - A new slot arriving while ref_pend=1 and also blocked is lost (ref_pend stays 1, no counter).
    - ref_pend is cleared at line_start.
- Exactly one gnt bit is set, or none. halt_L = ~|gnt.
- WSYNC:
  - wsync_wr sets wsync_stall on the next edge. RDY_L = ~wsync_stall.
  - wsync_stall clears on the edge where hcount==WSYNC_REL-1, so RDY_L is high during cycle WSYNC_REL.
  - wsync_wr while already stalled: no effect.
  - wsync_wr at hcount==WSYNC_REL-1: the stall begins and lasts until WSYNC_REL of the next line.
- DMACTL changes take effect in the same cycle, since decode is combinational. A grant in progress is not extended.
- Reset mid-line: counters restart at 0, all pending state is dropped, gnt is 0 while rst_L=0.

Decomposition:
- Package antic_pkg holds:
  - localparams for the slot cycle numbers (MIS_CYC, DL_CYC, PL_FIRST/LAST, LMS_FIRST/LAST, REF_FIRST, REF_STEP, REF_COUNT);
  - playfield window bounds per width code;
  - the gnt bit indices;
  - the DMACTL field positions.
- One sub-module, antic_beam_counter: hcount/vline counters plus line_start, vblank, vbi_start and VCOUNT. The arbitration, refresh and WSYNC logic stays in the top.

Test Plan:
- Reset, DMACTL=8'h2E (normal pf, players, missiles, DL), dl_req=1, pf_req=1, pf_rate=10, line 8: gnt=mis@0, dl@1, pl@2..5, pf on even cycles 20..98, ref@25,29,…,57 (odd, unblocked); halt_L low exactly in those cycles.
- pf_rate=11, normal width: pf granted every cycle 20..99. Refresh@25 blocked, so ref_pend=1; ref granted at 100. Slots 29..57 lost. REF_L low only at 100.
- vline=0 (vblank), DMACTL=8'h3F: no mis/dl/pl/lms/pf grants; ref@25..57 only. vbi_start pulses at vline 248, hcount 7.
- wsync_wr at hcount 40: RDY_L low at 41..104, high at 105. wsync_wr at 104: RDY_L low until hcount 105 of the next line.
- lms_req=1, DMACTL[5]=1, active line: gnt[lms] at hcount 6 and 7. DMACTL[5]=0: no dl/lms grants.
- Counter wrap: after 114×262 cycles hcount=0, vline=0; VCOUNT reaches 130 (vline 261). Asserting rst_L=0 at hcount 60 immediately zeros gnt and counters.
